hls_deadlock_multi_monitor: RTL and testbench
=============================================

HLS_DEADLOCK_MULTI_MONITOR -- requirements
Module: hls_deadlock_multi_monitor

Interface
REQ-001 The block SHALL have parameter NUM_AXIS, default 4, number of AXI-stream block inputs (>=1).
REQ-002 The block SHALL have parameter NUM_INST, default 2, number of sub-instance idle/block pairs (>=1).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 16, consecutive suspect cycles before declaring deadlock (>=1).
REQ-004 The block SHALL have parameter EVT_W, default 8, deadlock event counter width.
REQ-005 The block SHALL have port clock, input, 1, the single clock; all state updates on rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port axis_block_sigs, input, NUM_AXIS, per-channel stream-blocked flags.
REQ-008 The block SHALL have port inst_idle_sigs, input, NUM_INST, per-instance idle flags.
REQ-009 The block SHALL have port inst_block_sigs, input, NUM_INST, per-instance blocked flags.
REQ-010 The block SHALL have port clear, input, 1, synchronous clear pulse for the sticky flag and counter.
REQ-011 The block SHALL have port block, output, 1, live deadlock indication.
REQ-012 The block SHALL have port block_sticky, output, 1, latched deadlock indication.
REQ-013 The block SHALL have port block_src, output, SRC_W=clog2(NUM_AXIS+NUM_INST), index of the first culprit.
REQ-014 The block SHALL have port evt_cnt, output, EVT_W, number of deadlock entries.

Function
REQ-015 The block SHALL compute inst_stall = AND(inst_idle_sigs | inst_block_sigs) AND OR(inst_block_sigs), combinationally.
REQ-016 The block SHALL compute cand = OR(axis_block_sigs) | inst_stall, combinationally.
REQ-017 The block SHALL implement the FSM states IDLE, SUSPECT, DEADLOCK with a persistence counter cnt.
REQ-018 In IDLE, cand=1 SHALL move the FSM to SUSPECT with cnt=1, or directly to DEADLOCK when HOLD_CYCLES=1.
REQ-019 In SUSPECT, cand=0 SHALL return the FSM to IDLE with cnt=0; cand=1 with cnt=HOLD_CYCLES-1 SHALL enter DEADLOCK; otherwise cnt SHALL increment.
REQ-020 In DEADLOCK, cand=0 SHALL return the FSM to IDLE with cnt=0; cand=1 SHALL hold DEADLOCK.
REQ-021 Output block SHALL be registered and equal to (state==DEADLOCK); it asserts at the edge that samples the HOLD_CYCLES-th consecutive cand=1 and deasserts at the first edge that samples cand=0.
REQ-022 With HOLD_CYCLES=1, block SHALL equal cand delayed by exactly one cycle.
REQ-023 block_sticky SHALL set on entry to DEADLOCK and clear on clear=1; a simultaneous entry and clear SHALL leave it set.
REQ-024 On entry to DEADLOCK, block_src SHALL capture the lowest set index of axis_block_sigs, or, if none is set, NUM_AXIS plus the lowest set index of inst_block_sigs; otherwise it SHALL hold.
REQ-025 evt_cnt SHALL increment on each entry to DEADLOCK and saturate at all-ones; clear SHALL zero it; a simultaneous entry and clear SHALL yield 1.
REQ-026 The FSM SHALL re-enter DEADLOCK only after passing through IDLE, so that a continuous deadlock counts once.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state=IDLE, cnt=0, block=0, block_sticky=0, block_src=0, evt_cnt=0, including in mid-SUSPECT or mid-DEADLOCK.
REQ-028 The first edge after reset_n deasserts SHALL evaluate from IDLE.

Configuration
REQ-029 When HLS_DEADLOCK_MON_CAPTURE_EN is defined, block_src and evt_cnt SHALL behave as in REQ-024 and REQ-025.
REQ-030 When HLS_DEADLOCK_MON_CAPTURE_EN is undefined, block_src and evt_cnt SHALL be constant 0 with no capture registers, and block and block_sticky SHALL be unchanged.

Structure
REQ-031 Package hls_deadlock_pkg SHALL hold the FSM state enum (IDLE=0, SUSPECT=1, DEADLOCK=2) and the SRC_W/counter-width helper function.
REQ-032 The lowest-index selection SHALL be a separate sub-module hls_deadlock_prio_enc, parametrised by width, with outputs index and valid.

Verification
REQ-033 With HOLD_CYCLES=4 and axis_block_sigs=4'b0100 held 4 cycles, block SHALL rise at the 4th edge, block_src SHALL be 2, and evt_cnt SHALL be 1.
REQ-034 With HOLD_CYCLES=4 and cand high 3 cycles, low 1 cycle, high 3 cycles, block SHALL stay 0 and evt_cnt SHALL stay 0.
REQ-035 With inst_idle_sigs=2'b01 and inst_block_sigs=2'b10 held for HOLD_CYCLES, block SHALL be 1 and block_src SHALL be 5 (NUM_AXIS=4); with inst_block_sigs=0, block SHALL stay 0.
REQ-036 After two separate deadlocks, then clear, block_sticky SHALL go 0 and evt_cnt SHALL go 0; a clear coinciding with a third entry SHALL give evt_cnt=1 and block_sticky=1.
REQ-037 With EVT_W=2 and 5 deadlock entries, evt_cnt SHALL be 3; reset_n pulsed low mid-DEADLOCK SHALL zero all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hls_deadlock_pkg.sv
// Shared types and width helpers for the HLS deadlock monitor.
// The FSM state encoding and the index/counter width functions live here.
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StSuspect  = 2'd1,
    StDeadlock = 2'd2
  } state_e;

  // Bits needed to hold an index in [0, n-1]; never less than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold a persistence count in [0, hold].
  function automatic int unsigned cnt_width(int unsigned hold);
    return idx_width(hold + 1);
  endfunction

endpackage

// File: rtl/hls_deadlock_prio_enc.sv
// Lowest-index-first priority encoder used to name the deadlock culprit.
module hls_deadlock_prio_enc
  import hls_deadlock_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]            req_i,
  output logic [idx_width(WIDTH)-1:0] index_o,
  output logic                        valid_o
);

  localparam int unsigned IdxW = idx_width(WIDTH);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    index_o = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        index_o = IdxW'(i);
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/hls_deadlock_multi_monitor.sv
// Deadlock monitor: flags a stall that persists for HOLD_CYCLES consecutive cycles.
// Culprit capture and event counting exist only with HLS_DEADLOCK_MON_CAPTURE_EN.
module hls_deadlock_multi_monitor
  import hls_deadlock_pkg::*;
#(
  parameter int unsigned NUM_AXIS    = 4,
  parameter int unsigned NUM_INST    = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned EVT_W       = 8
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic [NUM_AXIS-1:0]                     axis_block_sigs,
  input  logic [NUM_INST-1:0]                     inst_idle_sigs,
  input  logic [NUM_INST-1:0]                     inst_block_sigs,
  input  logic                                    clear,
  output logic                                    block,
  output logic                                    block_sticky,
  output logic [idx_width(NUM_AXIS+NUM_INST)-1:0] block_src,
  output logic [EVT_W-1:0]                        evt_cnt
);

  localparam int unsigned SrcW = idx_width(NUM_AXIS + NUM_INST);
  localparam int unsigned CntW = cnt_width(HOLD_CYCLES);

  logic   inst_stall;
  logic   cand;
  logic   enter;
  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic   block_q, block_d;
  logic   sticky_q, sticky_d;

  // Every instance is idle or blocked, and at least one is blocked.
  assign inst_stall = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
  assign cand       = (|axis_block_sigs) | inst_stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (cand) begin
          cnt_d   = CntW'(1);
          state_d = (HOLD_CYCLES == 1) ? StDeadlock : StSuspect;
        end
      end
      StSuspect: begin
        if (!cand) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
          state_d = StDeadlock;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDeadlock: begin
        if (!cand) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Deadlock is only entered from outside it, so a continuous stall counts once.
  assign enter    = (state_q != StDeadlock) && (state_d == StDeadlock);
  assign block_d  = (state_d == StDeadlock);
  assign sticky_d = enter ? 1'b1 : (clear ? 1'b0 : sticky_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      block_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      block_q  <= block_d;
      sticky_q <= sticky_d;
    end
  end

  assign block        = block_q;
  assign block_sticky = sticky_q;

`ifdef HLS_DEADLOCK_MON_CAPTURE_EN
  logic [idx_width(NUM_AXIS)-1:0] axis_idx;
  logic                           axis_vld;
  logic [idx_width(NUM_INST)-1:0] inst_idx;
  logic                           inst_vld;
  logic [SrcW-1:0]                src_q, src_d;
  logic [EVT_W-1:0]               evt_q, evt_d;

  hls_deadlock_prio_enc #(
    .WIDTH (NUM_AXIS)
  ) u_axis_enc (
    .req_i   (axis_block_sigs),
    .index_o (axis_idx),
    .valid_o (axis_vld)
  );

  hls_deadlock_prio_enc #(
    .WIDTH (NUM_INST)
  ) u_inst_enc (
    .req_i   (inst_block_sigs),
    .index_o (inst_idx),
    .valid_o (inst_vld)
  );

  always_comb begin
    src_d = src_q;
    if (enter) begin
      if (axis_vld) begin
        src_d = SrcW'(axis_idx);
      end else if (inst_vld) begin
        src_d = SrcW'(NUM_AXIS) + SrcW'(inst_idx);
      end
    end
  end

  always_comb begin
    evt_d = evt_q;
    if (clear) begin
      evt_d = enter ? EVT_W'(1) : '0;
    end else if (enter && (evt_q != '1)) begin
      evt_d = evt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_q <= '0;
      evt_q <= '0;
    end else begin
      src_q <= src_d;
      evt_q <= evt_d;
    end
  end

  assign block_src = src_q;
  assign evt_cnt   = evt_q;
`else
  assign block_src = '0;
  assign evt_cnt   = '0;
`endif

endmodule

// File: tb/tb_hls_deadlock_multi_monitor.sv
// Bench for hls_deadlock_multi_monitor: two instances (HOLD 4 / EVT_W 8 and
// HOLD 1 / EVT_W 2) share stimulus and are compared against a run-length model.
module tb_hls_deadlock_multi_monitor;

  localparam int NA = 4;
  localparam int NI = 2;

`ifdef HLS_DEADLOCK_MON_CAPTURE_EN
  localparam bit Cap = 1'b1;
`else
  localparam bit Cap = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic [NA-1:0] axis = '0;
  logic [NI-1:0] idle = '0;
  logic [NI-1:0] blk = '0;

  logic       a_block, a_sticky, b_block, b_sticky;
  logic [2:0] a_src, b_src;
  logic [7:0] a_evt;
  logic [1:0] b_evt;

  always #5 clock = ~clock;

  hls_deadlock_multi_monitor #(
    .NUM_AXIS    (NA),
    .NUM_INST    (NI),
    .HOLD_CYCLES (4),
    .EVT_W       (8)
  ) dut_a (
    .clock           (clock),
    .reset_n         (reset_n),
    .axis_block_sigs (axis),
    .inst_idle_sigs  (idle),
    .inst_block_sigs (blk),
    .clear           (clear),
    .block           (a_block),
    .block_sticky    (a_sticky),
    .block_src       (a_src),
    .evt_cnt         (a_evt)
  );

  hls_deadlock_multi_monitor #(
    .NUM_AXIS    (NA),
    .NUM_INST    (NI),
    .HOLD_CYCLES (1),
    .EVT_W       (2)
  ) dut_b (
    .clock           (clock),
    .reset_n         (reset_n),
    .axis_block_sigs (axis),
    .inst_idle_sigs  (idle),
    .inst_block_sigs (blk),
    .clear           (clear),
    .block           (b_block),
    .block_sticky    (b_sticky),
    .block_src       (b_src),
    .evt_cnt         (b_evt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: consecutive stall cycles seen, plus sticky/source/event tallies.
  int hold [2] = '{4, 1};
  int emax [2] = '{255, 3};
  int run  [2];
  int m_sticky [2];
  int m_src [2];
  int m_evt [2];

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_cand();
    bit all_quiet = 1'b1;
    bit any_blk   = 1'b0;
    for (int j = 0; j < NI; j++) begin
      if (!(idle[j] || blk[j])) all_quiet = 1'b0;
      if (blk[j]) any_blk = 1'b1;
    end
    return (axis != 0) || (all_quiet && any_blk);
  endfunction

  function automatic int culprit();
    for (int i = 0; i < NA; i++) if (axis[i]) return i;
    for (int j = 0; j < NI; j++) if (blk[j]) return NA + j;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      run[k] = 0; m_sticky[k] = 0; m_src[k] = 0; m_evt[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit c = model_cand();
    for (int k = 0; k < 2; k++) begin
      bit entry;
      run[k] = c ? ((run[k] > hold[k]) ? run[k] : run[k] + 1) : 0;
      entry  = (run[k] == hold[k]);
      if (entry) m_sticky[k] = 1;
      else if (clear) m_sticky[k] = 0;
      if (entry) m_src[k] = culprit();
      if (clear) m_evt[k] = entry ? 1 : 0;
      else if (entry && m_evt[k] < emax[k]) m_evt[k]++;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_a_block"}, a_block, (run[0] >= hold[0]) ? 1 : 0);
    check_eq({tag, "_a_sticky"}, a_sticky, m_sticky[0]);
    check_eq({tag, "_a_src"}, a_src, Cap ? m_src[0] : 0);
    check_eq({tag, "_a_evt"}, a_evt, Cap ? m_evt[0] : 0);
    check_eq({tag, "_b_block"}, b_block, (run[1] >= hold[1]) ? 1 : 0);
    check_eq({tag, "_b_sticky"}, b_sticky, m_sticky[1]);
    check_eq({tag, "_b_src"}, b_src, Cap ? m_src[1] : 0);
    check_eq({tag, "_b_evt"}, b_evt, Cap ? m_evt[1] : 0);
  endtask

  task automatic step(input string tag, input logic [NA-1:0] ax, input logic [NI-1:0] id,
                      input logic [NI-1:0] bk, input logic clr);
    axis = ax; idle = id; blk = bk; clear = clr;
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    axis = '0; idle = '0; blk = '0; clear = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step("quiet", '0, '0, '0, 1'b0);
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Single channel held for exactly HOLD cycles.
    for (int i = 0; i < 4; i++) step("hold4", 4'b0100, '0, '0, 1'b0);
    check_eq("hold4_block", a_block, 1);
    check_eq("hold4_src", a_src, Cap ? 2 : 0);
    check_eq("hold4_evt", a_evt, Cap ? 1 : 0);
    quiet(2);

    // Stall interrupted one cycle short of the threshold never fires.
    do_reset("rst2");
    for (int i = 0; i < 3; i++) step("gap_hi1", 4'b0001, '0, '0, 1'b0);
    step("gap_lo", '0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step("gap_hi2", 4'b1000, '0, '0, 1'b0);
    check_eq("gap_block", a_block, 0);
    check_eq("gap_evt", a_evt, 0);
    quiet(1);

    // Instance-level stall: inst0 idle, inst1 blocked -> culprit NUM_AXIS+1.
    for (int i = 0; i < 4; i++) step("inst", '0, 2'b01, 2'b10, 1'b0);
    check_eq("inst_block", a_block, 1);
    check_eq("inst_src", a_src, Cap ? 5 : 0);
    quiet(1);
    for (int i = 0; i < 5; i++) step("inst_idle", '0, 2'b01, 2'b00, 1'b0);
    check_eq("inst_noblk", a_block, 0);

    // Two deadlocks, clear, then a clear landing on a third entry.
    do_reset("rst3");
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 5; i++) step("dl", 4'b0010, '0, '0, 1'b0);
      quiet(1);
    end
    step("clr", '0, '0, '0, 1'b1);
    check_eq("clr_sticky", a_sticky, 0);
    check_eq("clr_evt", a_evt, 0);
    for (int i = 0; i < 3; i++) step("dl3", 4'b0010, '0, '0, 1'b0);
    step("dl3_clr", 4'b0010, '0, '0, 1'b1);
    check_eq("coin_evt", a_evt, Cap ? 1 : 0);
    check_eq("coin_sticky", a_sticky, 1);

    // Saturation of the 2-bit counter in the HOLD=1 instance.
    do_reset("rst4");
    for (int d = 0; d < 5; d++) begin
      step("sat_hi", 4'b0001, '0, '0, 1'b0);
      step("sat_lo", '0, '0, '0, 1'b0);
    end
    check_eq("sat_evt", b_evt, Cap ? 3 : 0);

    // Asynchronous reset while both instances sit in deadlock.
    for (int i = 0; i < 5; i++) step("pre_rst", 4'b0001, '0, '0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check_eq("arst_a_block", a_block, 0);
    check_eq("arst_a_sticky", a_sticky, 0);
    check_eq("arst_a_evt", a_evt, 0);
    check_eq("arst_b_block", b_block, 0);
    model_reset();
    axis = '0;
    @(negedge clock);
    reset_n = 1'b1;

    // Randomized bursts with occasional clears.
    for (int n = 0; n < 120; n++) begin
      logic [NA-1:0] ax;
      logic [NI-1:0] id, bk;
      int len;
      ax  = ($urandom_range(0, 2) == 0) ? NA'($urandom) : '0;
      id  = NI'($urandom);
      bk  = NI'($urandom);
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        step("rand", ax, id, bk, ($urandom_range(0, 9) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
